// File: rtl/mcyc_memif.sv
// mcyc_memif: multicycle memory-access sequencer.
// Owns PC, IR, MDR and MAR and runs fetch/load/store transactions against a
// variable-latency memory using a ready handshake. A wait-state timeout raises
// a sticky fault.
// Optional build macro: MEMIF_ALIGN_CHECK_EN enables the address alignment
// check at request accept (misaligned requests fault instead of issuing).
module mcyc_memif #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter int                MAX_WAIT = 15
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iReqFetch,
  input  logic              iReqLoad,
  input  logic              iReqStore,
  input  logic [ADDR_W-1:0] iDataAddr,
  input  logic [DATA_W-1:0] iStoreData,
  input  logic              iPcLoad,
  input  logic [ADDR_W-1:0] iPcValue,
  output logic [ADDR_W-1:0] oPC,
  output logic [DATA_W-1:0] oIR,
  output logic [DATA_W-1:0] oMDR,
  output logic              oBusy,
  output logic              oDone,
  output logic              oFault,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  output logic              oMemRead,
  output logic              oMemWrite,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemReady
);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [7:0]        wait_q, wait_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic              req_any;
  op_t               op_sel;
  logic [ADDR_W-1:0] acc_addr;
  logic              misaligned;

  // Request decode: fixed priority fetch > load > store.
  always_comb begin
    req_any  = iReqFetch | iReqLoad | iReqStore;
    op_sel   = iReqFetch ? OP_FETCH : (iReqLoad ? OP_LOAD : OP_STORE);
    acc_addr = iReqFetch ? pc_q : iDataAddr;
  end

`ifdef MEMIF_ALIGN_CHECK_EN
  localparam int                ALIGN_BITS = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_BITS) - 1);

  // Alignment check on the address the accepted request would use.
  always_comb begin
    misaligned = |(acc_addr & ALIGN_MASK);
  end
`else
  // No alignment check: every address goes to memory unchanged.
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers owned by the sequencer.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      op_q    <= OP_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      mar_q   <= '0;
      sdata_q <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      mar_q   <= mar_d;
      sdata_q <= sdata_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    mar_d   = mar_q;
    sdata_d = sdata_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iPcLoad) begin
          pc_d = iPcValue;
        end else if (req_any) begin
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            op_d    = op_sel;
            mar_d   = acc_addr;
            sdata_d = iStoreData;
            fault_d = 1'b0;
            wait_d  = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // Ready takes precedence over the timeout on the same edge.
        if (iMemReady) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          unique case (op_q)
            OP_FETCH: begin
              ir_d = iMemData;
              pc_d = pc_q + ADDR_W'(PC_STEP);
            end
            OP_LOAD:  mdr_d = iMemData;
            default:  ;
          endcase
        end else if (wait_q == 8'(MAX_WAIT)) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: strobes decoded from state so reset drops them at once.
  always_comb begin
    oBusy     = (state_q == ST_ACCESS);
    oMemRead  = oBusy && (op_q != OP_STORE);
    oMemWrite = oBusy && (op_q == OP_STORE);
    oMemData  = oMemWrite ? sdata_q : '0;
    oMemAddr  = mar_q;
    oPC       = pc_q;
    oIR       = ir_q;
    oMDR      = mdr_q;
    oDone     = done_q;
    oFault    = fault_q;
  end

endmodule
